// File: rtl/wfg_drive_pat_seq.sv
// -----------------------------------------------------------------------------
// wfg_drive_pat_seq
//
// Pattern sequencer for the waveform generator drive block. It accepts one
// AXI-Stream word per pattern cycle and holds that word on the channel outputs
// until the next sync. It also broadcasts the current subcycle index to every
// channel.
//
// Parameters
//   CHANNELS            number of pattern channels (= AXI-Stream data width)
//
// Ports
//   clk                 system clock, rising edge
//   rst_n               asynchronous active-low reset
//   ctrl_en_q_i         block enable; 0 forces IDLE and clears the outputs
//   cfg_subcycle_q_i    last subcycle index (cycle length = value + 1)
//   wfg_pat_sync_i      pulse marking the start of a pattern cycle
//   wfg_pat_subcycle_i  pulse marking a subcycle boundary
//   wfg_axis_tdata_i    pattern word, bit n -> channel n
//   wfg_axis_tvalid_i   AXI-Stream valid
//   wfg_axis_tready_o   AXI-Stream ready (combinational, only during a sync)
//   pat_subcycle_cnt_o  current subcycle index
//   axis_data_o         held pattern word
//   underflow_o         one-cycle pulse: a sync found no word available
//   underflow_cnt_o     saturating underflow count; this port exists only
//                       when WFG_DRIVE_PAT_SEQ_UNDERFLOW_CNT_EN is defined
//
// Optional feature macro: WFG_DRIVE_PAT_SEQ_UNDERFLOW_CNT_EN
// -----------------------------------------------------------------------------
module wfg_drive_pat_seq #(
  parameter int unsigned CHANNELS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ctrl_en_q_i,
  input  logic [7:0]          cfg_subcycle_q_i,
  input  logic                wfg_pat_sync_i,
  input  logic                wfg_pat_subcycle_i,
  input  logic [CHANNELS-1:0] wfg_axis_tdata_i,
  input  logic                wfg_axis_tvalid_i,
  output logic                wfg_axis_tready_o,
  output logic [7:0]          pat_subcycle_cnt_o,
  output logic [CHANNELS-1:0] axis_data_o,
`ifdef WFG_DRIVE_PAT_SEQ_UNDERFLOW_CNT_EN
  output logic [15:0]         underflow_cnt_o,
`endif
  output logic                underflow_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [CHANNELS-1:0] data_q, data_d;
  logic                underflow_q, underflow_d;
  logic                sync_evt;

  // A sync is only honoured once the block has been enabled and has left
  // IDLE. Ready is offered exactly in that cycle, which limits the stream to
  // one transfer per sync.
  assign sync_evt          = (state_q != IDLE) && wfg_pat_sync_i && ctrl_en_q_i;
  assign wfg_axis_tready_o = sync_evt;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    underflow_d = 1'b0;

    if (!ctrl_en_q_i) begin
      // Disable overrides every other event.
      state_d = IDLE;
      cnt_d   = '0;
      data_d  = '0;
    end else begin
      unique case (state_q)
        IDLE:      state_d = WAIT_SYNC;
        WAIT_SYNC: if (wfg_pat_sync_i) state_d = RUN;
        RUN:       state_d = RUN;
        default:   state_d = IDLE;
      endcase

      if (sync_evt) begin
        // New word and index 0 appear on the same edge. A sync that
        // coincides with a subcycle pulse is treated as a sync only.
        cnt_d = '0;
        if (wfg_axis_tvalid_i) begin
          data_d = wfg_axis_tdata_i;
        end else begin
          underflow_d = 1'b1;
        end
      end else if ((state_q == RUN) && wfg_pat_subcycle_i &&
                   (cnt_q < cfg_subcycle_q_i)) begin
        // A strict compare gives saturation at the configured limit. It also
        // freezes the counter if the limit is lowered below the current
        // count, so the counter never counts down.
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      underflow_q <= underflow_d;
    end
  end

  assign pat_subcycle_cnt_o = cnt_q;
  assign axis_data_o        = data_q;
  assign underflow_o        = underflow_q;

`ifdef WFG_DRIVE_PAT_SEQ_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // The count is advanced together with the underflow pulse register. This
  // way the count already includes a pulse while that pulse is visible.
  always_comb begin
    ucnt_d = ucnt_q;
    if (!ctrl_en_q_i) begin
      ucnt_d = '0;
    end else if (underflow_d && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underflow_cnt_o = ucnt_q;
`endif

endmodule

// File: tb/tb_wfg_drive_pat_seq.sv
// -----------------------------------------------------------------------------
// tb_wfg_drive_pat_seq
//
// Directed testbench for wfg_drive_pat_seq. It uses hand-computed expected
// values and immediate-assertion checks. Inputs change 1 ns after the rising
// edge. Registered outputs are checked at that same point. Combinational ready
// is checked 1 ns after the inputs change.
// -----------------------------------------------------------------------------
module tb_wfg_drive_pat_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ctrl_en_q_i;
  logic [7:0]  cfg_subcycle_q_i;
  logic        wfg_pat_sync_i;
  logic        wfg_pat_subcycle_i;
  logic [31:0] wfg_axis_tdata_i;
  logic        wfg_axis_tvalid_i;
  logic        wfg_axis_tready_o;
  logic [7:0]  pat_subcycle_cnt_o;
  logic [31:0] axis_data_o;
  logic        underflow_o;
`ifdef WFG_DRIVE_PAT_SEQ_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt_o;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  wfg_drive_pat_seq #(.CHANNELS(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ctrl_en_q_i        (ctrl_en_q_i),
    .cfg_subcycle_q_i   (cfg_subcycle_q_i),
    .wfg_pat_sync_i     (wfg_pat_sync_i),
    .wfg_pat_subcycle_i (wfg_pat_subcycle_i),
    .wfg_axis_tdata_i   (wfg_axis_tdata_i),
    .wfg_axis_tvalid_i  (wfg_axis_tvalid_i),
    .wfg_axis_tready_o  (wfg_axis_tready_o),
    .pat_subcycle_cnt_o (pat_subcycle_cnt_o),
    .axis_data_o        (axis_data_o),
`ifdef WFG_DRIVE_PAT_SEQ_UNDERFLOW_CNT_EN
    .underflow_cnt_o    (underflow_cnt_o),
`endif
    .underflow_o        (underflow_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[TB] %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b1; ctrl_en_q_i = 1'b1; cfg_subcycle_q_i = 8'd3;
    wfg_pat_sync_i = 1'b1; wfg_pat_subcycle_i = 1'b0;
    wfg_axis_tdata_i = 32'hDEAD_BEEF; wfg_axis_tvalid_i = 1'b1;
    #3 rst_n = 1'b0;

    // Reset holds everything off, even with sync/valid/enable active.
    tick(); tick();
    check("rst_tready", {31'd0, wfg_axis_tready_o}, 32'd0);
    check("rst_cnt", {24'd0, pat_subcycle_cnt_o}, 32'd0);
    check("rst_data", axis_data_o, 32'd0);
    check("rst_uf", {31'd0, underflow_o}, 32'd0);

    // Release reset while disabled.
    rst_n = 1'b1; ctrl_en_q_i = 1'b0;
    wfg_pat_sync_i = 1'b0; wfg_axis_tvalid_i = 1'b0;
    tick();
    check("dis_data", axis_data_o, 32'd0);

    // Enable: IDLE -> WAIT_SYNC.
    ctrl_en_q_i = 1'b1;
    tick();

    // Valid held without sync is stalled. Subcycles are ignored while waiting.
    wfg_axis_tvalid_i = 1'b1; wfg_axis_tdata_i = 32'hA5A5_0F0F; wfg_pat_subcycle_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 check("stall_tready", {31'd0, wfg_axis_tready_o}, 32'd0);
      tick();
    end
    check("stall_cnt", {24'd0, pat_subcycle_cnt_o}, 32'd0);
    check("stall_data", axis_data_o, 32'd0);

    // Sync with valid: transfer; data visible one clock later.
    wfg_pat_subcycle_i = 1'b0; wfg_pat_sync_i = 1'b1;
    #1 check("sync_tready", {31'd0, wfg_axis_tready_o}, 32'd1);
    tick();
    check("xfer_data", axis_data_o, 32'hA5A5_0F0F);
    check("xfer_cnt", {24'd0, pat_subcycle_cnt_o}, 32'd0);
    wfg_pat_sync_i = 1'b0; wfg_axis_tvalid_i = 1'b0;
    #1 check("post_tready", {31'd0, wfg_axis_tready_o}, 32'd0);

    // Four subcycle pulses with cfg=3: 1,2,3,3.
    wfg_pat_subcycle_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("sub_cnt", {24'd0, pat_subcycle_cnt_o}, (i > 3) ? 32'd3 : i);
    end

    // Lowering cfg below the count freezes the counter.
    cfg_subcycle_q_i = 8'd1;
    tick();
    check("freeze_cnt", {24'd0, pat_subcycle_cnt_o}, 32'd3);
    cfg_subcycle_q_i = 8'd3; wfg_pat_subcycle_i = 1'b0;

    // Load word 1, then advance to cnt=2.
    wfg_pat_sync_i = 1'b1; wfg_axis_tvalid_i = 1'b1; wfg_axis_tdata_i = 32'h1;
    tick();
    check("w1_data", axis_data_o, 32'h1);
    wfg_pat_sync_i = 1'b0; wfg_axis_tvalid_i = 1'b0; wfg_pat_subcycle_i = 1'b1;
    tick(); tick();
    check("pre_cnt", {24'd0, pat_subcycle_cnt_o}, 32'd2);

    // Sync and subcycle together, no valid: cnt=0, data held, underflow pulse.
    wfg_pat_sync_i = 1'b1; wfg_axis_tdata_i = 32'h55;
    #1 check("uf_tready", {31'd0, wfg_axis_tready_o}, 32'd1);
    tick();
    check("both_cnt", {24'd0, pat_subcycle_cnt_o}, 32'd0);
    check("uf_data", axis_data_o, 32'h1);
    check("uf_pulse", {31'd0, underflow_o}, 32'd1);
    wfg_pat_sync_i = 1'b0; wfg_pat_subcycle_i = 1'b0;
    tick();
    check("uf_end", {31'd0, underflow_o}, 32'd0);
`ifdef WFG_DRIVE_PAT_SEQ_UNDERFLOW_CNT_EN
    check("uf_count", {16'd0, underflow_cnt_o}, 32'd1);
`endif

    // Reach cnt=5 with all-ones data, then drop enable.
    cfg_subcycle_q_i = 8'd7;
    wfg_pat_sync_i = 1'b1; wfg_axis_tvalid_i = 1'b1; wfg_axis_tdata_i = 32'hFFFF_FFFF;
    tick();
    check("ones_data", axis_data_o, 32'hFFFF_FFFF);
    wfg_pat_sync_i = 1'b0; wfg_axis_tvalid_i = 1'b0; wfg_pat_subcycle_i = 1'b1;
    repeat (5) tick();
    check("five_cnt", {24'd0, pat_subcycle_cnt_o}, 32'd5);
    wfg_pat_subcycle_i = 1'b0;
    ctrl_en_q_i = 1'b0; wfg_pat_sync_i = 1'b1; wfg_axis_tvalid_i = 1'b1; wfg_axis_tdata_i = 32'h77;
    #1 check("dis_tready", {31'd0, wfg_axis_tready_o}, 32'd0);
    tick();
    check("dis_cnt", {24'd0, pat_subcycle_cnt_o}, 32'd0);
    check("dis_data0", axis_data_o, 32'd0);
    repeat (3) tick();
    check("dis_sync_ign", axis_data_o, 32'd0);
    check("dis_uf", {31'd0, underflow_o}, 32'd0);
`ifdef WFG_DRIVE_PAT_SEQ_UNDERFLOW_CNT_EN
    check("dis_ucnt", {16'd0, underflow_cnt_o}, 32'd0);
`endif

    // Re-enable: subcycles ignored until sync, then a new word loads.
    ctrl_en_q_i = 1'b1; wfg_pat_sync_i = 1'b0; wfg_axis_tvalid_i = 1'b0; wfg_pat_subcycle_i = 1'b1;
    tick(); tick();
    check("wait_cnt", {24'd0, pat_subcycle_cnt_o}, 32'd0);
    wfg_pat_subcycle_i = 1'b0; wfg_pat_sync_i = 1'b1; wfg_axis_tvalid_i = 1'b1;
    wfg_axis_tdata_i = 32'h1234_5678;
    tick();
    check("reen_data", axis_data_o, 32'h1234_5678);
    wfg_pat_sync_i = 1'b0; wfg_axis_tvalid_i = 1'b0; wfg_pat_subcycle_i = 1'b1;
    tick(); tick();
    check("reen_cnt", {24'd0, pat_subcycle_cnt_o}, 32'd2);

    // Asynchronous reset mid-RUN clears outputs without waiting for an edge.
    wfg_pat_subcycle_i = 1'b0;
    wfg_pat_sync_i = 1'b1; wfg_axis_tvalid_i = 1'b1; wfg_axis_tdata_i = 32'hCAFE_F00D;
    rst_n = 1'b0;
    #1;
    check("arst_cnt", {24'd0, pat_subcycle_cnt_o}, 32'd0);
    check("arst_data", axis_data_o, 32'd0);
    check("arst_uf", {31'd0, underflow_o}, 32'd0);
    check("arst_tready", {31'd0, wfg_axis_tready_o}, 32'd0);
    tick();

    // After release: IDLE first, so the first sync is not accepted.
    rst_n = 1'b1;
    #1 check("rel_tready", {31'd0, wfg_axis_tready_o}, 32'd0);
    tick();
    check("rel_data", axis_data_o, 32'd0);
    #1 check("rel_tready2", {31'd0, wfg_axis_tready_o}, 32'd1);
    tick();
    check("rel_xfer", axis_data_o, 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
